// File: rtl/cascaded_sequential_adder.sv
// N-bit adder built from N/W ripple-carry stages of W bits each, with the
// (N+1)-bit result {cout, s} captured in a single output register.
module cascaded_sequential_adder #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int STAGES = N / W;

  logic [N-1:0] sum_s;
  logic         cout_s;
  logic [N-1:0] sum_r;
  logic         cout_r;

  // 1-bit full adder, returns {carry, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic p;
    p = x ^ y;
    return {(x & y) | (c & p), p ^ c};
  endfunction

  // Combinational cascade: each stage ripples its bits and hands its carry to the next stage
  always_comb begin : p_cascade
    logic       stage_c;
    logic       bit_c;
    logic [1:0] fa;
    sum_s   = '0;
    cout_s  = 1'b0;
    stage_c = cin;
    bit_c   = 1'b0;
    fa      = 2'b00;
    for (int k = 0; k < STAGES; k++) begin
      bit_c = stage_c;
      for (int i = 0; i < W; i++) begin
        fa             = full_add(a[k*W+i], b[k*W+i], bit_c);
        sum_s[k*W+i]   = fa[0];
        bit_c          = fa[1];
      end
      stage_c = bit_c;
    end
    cout_s = stage_c;
  end

  // Result register; reset clears the held sum immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      sum_r  <= sum_s;
      cout_r <= cout_s;
    end
  end

  assign s    = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_cascaded_sequential_adder.sv
// Self-checking bench for cascaded_sequential_adder at N=32/W=8 and N=16/W=4,
// compared against plain integer addition.
module tb_cascaded_sequential_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, s32;
  logic        cin, cout32;
  logic [15:0] a16, b16, s16;
  logic        cout16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  cascaded_sequential_adder #(.N(32), .W(8)) dut32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s32), .cout(cout32)
  );

  cascaded_sequential_adder #(.N(16), .W(4)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin), .s(s16), .cout(cout16)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 33'(c);
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
    a16 = va[15:0];
    b16 = vb[15:0];
  endtask

  // one rising edge, then compare both instances one time unit later
  task automatic clock_and_check(input string name, input logic [32:0] exp32);
    logic [16:0] e16;
    e16 = ref16(a16, b16, cin);
    @(posedge clk);
    #1;
    check(name, {cout32, s32}, exp32);
    check({name, "_n16"}, {16'b0, cout16, s16}, {16'b0, e16});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    int          mode;

    vecs[0] = '{32'd283,        32'd50,         1'b0, 32'd333,        1'b0};
    vecs[1] = '{32'h0000_00FF,  32'h0000_0001,  1'b0, 32'h0000_0100,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 32'h0000_0000,  1'b1};
    vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1};
    vecs[4] = '{32'h0000_0000,  32'h0000_0000,  1'b0, 32'h0000_0000,  1'b0};
    vecs[5] = '{32'h0000_FFFF,  32'h0000_0000,  1'b1, 32'h0001_0000,  1'b0};
    vecs[6] = '{32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 32'h8000_0000,  1'b0};

    // reset asserts without a clock edge and holds through one
    rst = 1'b0;
    drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("reset_async", {cout32, s32}, 33'd0);
    check("reset_async_n16", {16'b0, cout16, s16}, 33'd0);
    @(posedge clk);
    #1;
    check("reset_held", {cout32, s32}, 33'd0);
    check("reset_held_n16", {16'b0, cout16, s16}, 33'd0);
    rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      clock_and_check($sformatf("vec%0d", i), {vecs[i].cout, vecs[i].s});
    end

    // outputs stay put while inputs move between edges
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    clock_and_check("stable_load", 33'h0_2345_6789);
    drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    #3;
    check("stable_hold", {cout32, s32}, 33'h0_2345_6789);

    // incrementing operand sweep
    ra = 32'd283;
    rb = 32'd50;
    for (int i = 0; i < 200; i++) begin
      drive(ra, rb, 1'b0);
      clock_and_check("sweep", ref32(ra, rb, 1'b0));
      ra = ra + 32'd1318402;
      rb = rb + 32'd182553;
    end

    // reset mid-operation discards the held result
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    clock_and_check("half_ovf", {1'b1, 32'h0});
    #2 rst = 1'b1;
    #1;
    check("midrst", {cout32, s32}, 33'd0);
    check("midrst_n16", {16'b0, cout16, s16}, 33'd0);
    #1 rst = 1'b0;
    drive(32'd5, 32'd7, 1'b1);
    clock_and_check("after_rst", 33'd13);

    // constrained random, biased toward all-ones operands
    for (int i = 0; i < 10000; i++) begin
      mode = int'($urandom_range(0, 7));
      ra   = (mode == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb   = (mode == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      rc   = 1'($urandom_range(0, 1));
      drive(ra, rb, rc);
      clock_and_check("random", ref32(ra, rb, rc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
